dispense_controller: RTL and testbench

Sequencing and arbitration controller for the shared fluid dispenser. Up to NREQ kiosk requesters (each already tagged with its user's visit count by the visit tracker) compete for one dispensing head. The block grants one requester at a time round-robin, checks and debits per-fluid stock, and drives the valve for a timed pour. It then reports tiered price, loyalty discount and remaining stock with a one-cycle completion pulse.

---
 rtl/dispense_controller.sv | 218 +++++++++++++++++++++
 tb/tb_dispense_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dispense_controller.sv
// Shared fluid dispenser controller: round-robin grant, stock check/debit,
// timed valve pour and tiered price/discount reporting.
module dispense_controller #(
  parameter int NREQ        = 4,
  parameter int POUR_CYCLES = 4,
  parameter int WATER_INIT  = 100,
  parameter int JUICE_INIT  = 80,
  parameter int CHEM_INIT   = 60,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_fluid,
  input  logic [8*NREQ-1:0] req_volume,
  input  logic [8*NREQ-1:0] req_visits,
  input  logic              refill_valid,
  input  logic [1:0]        refill_fluid,
  input  logic [15:0]       refill_qty,
  output logic [NREQ-1:0]   gnt,
  output logic [2:0]        valve_open,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [1:0]        status,
  output logic [15:0]       original_price,
  output logic [7:0]        discount_percent,
  output logic [15:0]       final_price,
  output logic [15:0]       remaining_qty,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, CHECK, POUR, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] last_served;
  logic [IDW-1:0] sel_id;
  logic [1:0]     sel_fluid;
  logic [7:0]     sel_volume;
  logic [7:0]     sel_visits;
  logic [7:0]     litres_left;
  logic [15:0]    cyc_cnt;
  logic [15:0]    stock [3];
  logic [15:0]    pend_orig;
  logic [15:0]    pend_final;
  logic [7:0]     pend_disc;

  assign state_dbg = state;

  // Round-robin pick: first set req bit after last_served, wrapping.
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW-1:0] idx;
  logic [1:0]     pick_fluid;
  logic [7:0]     pick_volume;
  logic [7:0]     pick_visits;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = last_served + IDW'(i + 1);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    pick_fluid  = req_fluid[2*int'(pick) +: 2];
    pick_volume = req_volume[8*int'(pick) +: 8];
    pick_visits = req_visits[8*int'(pick) +: 8];
  end

  logic [15:0] sel_stock;
  logic [1:0]  chk_status;
  logic [15:0] price_calc;
  logic [15:0] base;
  logic [15:0] step;
  logic [7:0]  vm1;
  logic [7:0]  disc_calc;
  logic [23:0] prod;
  logic [23:0] cut;
  logic [15:0] final_calc;

  always_comb begin
    case (sel_fluid)
      2'd0:    begin sel_stock = stock[0]; base = 16'd20; step = 16'd10; end
      2'd1:    begin sel_stock = stock[1]; base = 16'd50; step = 16'd30; end
      default: begin sel_stock = stock[2]; base = 16'd40; step = 16'd20; end
    endcase
    if (sel_fluid == 2'd3)                 chk_status = 2'd2;
    else if (sel_volume == 8'd0)           chk_status = 2'd3;
    else if (sel_stock < {8'd0, sel_volume}) chk_status = 2'd1;
    else                                   chk_status = 2'd0;
    vm1        = sel_volume - 8'd1;
    price_calc = base + step * {8'd0, vm1};
    if (sel_visits <= 8'd2)      disc_calc = 8'd0;
    else if (sel_visits <= 8'd4) disc_calc = 8'd10;
    else                         disc_calc = 8'd20;
    prod       = {8'd0, price_calc} * {16'd0, disc_calc};
    cut        = prod / 24'd100;
    final_calc = price_calc - cut[15:0];
  end

  // Stock update: refill and pour debit may hit the same fluid together.
  logic        debit;
  logic [15:0] stock_next [3];
  logic [17:0] sum [3];
  logic [15:0] sel_stock_next;

  always_comb begin
    debit = (state == POUR) && (cyc_cnt == 16'(POUR_CYCLES - 1));
    for (int f = 0; f < 3; f++) begin
      sum[f] = {2'b00, stock[f]};
      if (refill_valid && refill_fluid == 2'(f)) sum[f] = sum[f] + {2'b00, refill_qty};
      if (debit && sel_fluid == 2'(f))           sum[f] = sum[f] - 18'd1;
      stock_next[f] = (sum[f] > 18'h0FFFF) ? 16'hFFFF : sum[f][15:0];
    end
    case (sel_fluid)
      2'd0:    sel_stock_next = stock_next[0];
      2'd1:    sel_stock_next = stock_next[1];
      2'd2:    sel_stock_next = stock_next[2];
      default: sel_stock_next = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_served      <= IDW'(NREQ - 1);
      sel_id           <= '0;
      sel_fluid        <= '0;
      sel_volume       <= '0;
      sel_visits       <= '0;
      litres_left      <= '0;
      cyc_cnt          <= '0;
      stock[0]         <= 16'(WATER_INIT);
      stock[1]         <= 16'(JUICE_INIT);
      stock[2]         <= 16'(CHEM_INIT);
      pend_orig        <= '0;
      pend_final       <= '0;
      pend_disc        <= '0;
      gnt              <= '0;
      valve_open       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      done_id          <= '0;
      status           <= '0;
      original_price   <= '0;
      discount_percent <= '0;
      final_price      <= '0;
      remaining_qty    <= '0;
    end else begin
      for (int f = 0; f < 3; f++) stock[f] <= stock_next[f];
      case (state)
        IDLE: begin
          if (found) begin
            sel_id     <= pick;
            sel_fluid  <= pick_fluid;
            sel_volume <= pick_volume;
            sel_visits <= pick_visits;
            gnt        <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            busy       <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (chk_status == 2'd0) begin
            pend_orig   <= price_calc;
            pend_final  <= final_calc;
            pend_disc   <= disc_calc;
            litres_left <= sel_volume;
            cyc_cnt     <= '0;
            valve_open  <= 3'b001 << sel_fluid;
            state       <= POUR;
          end else begin
            done             <= 1'b1;
            done_id          <= sel_id;
            status           <= chk_status;
            original_price   <= '0;
            final_price      <= '0;
            discount_percent <= disc_calc;
            remaining_qty    <= sel_stock_next;
            state            <= DONE;
          end
        end
        POUR: begin
          if (debit) begin
            cyc_cnt     <= '0;
            litres_left <= litres_left - 8'd1;
            if (litres_left == 8'd1) begin
              valve_open       <= '0;
              done             <= 1'b1;
              done_id          <= sel_id;
              status           <= 2'd0;
              original_price   <= pend_orig;
              final_price      <= pend_final;
              discount_percent <= pend_disc;
              remaining_qty    <= sel_stock_next;
              state            <= DONE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        DONE: begin
          done        <= 1'b0;
          gnt         <= '0;
          busy        <= 1'b0;
          last_served <= sel_id;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller: pricing, rejects, round-robin,
// refill saturation and asynchronous reset during a pour.
module tb_dispense_controller;
  localparam int NREQ = 4;
  localparam int PC   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_fluid;
  logic [31:0] req_volume;
  logic [31:0] req_visits;
  logic        refill_valid;
  logic [1:0]  refill_fluid;
  logic [15:0] refill_qty;
  logic [3:0]  gnt;
  logic [2:0]  valve_open;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [1:0]  status;
  logic [15:0] original_price;
  logic [7:0]  discount_percent;
  logic [15:0] final_price;
  logic [15:0] remaining_qty;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  dispense_controller #(.NREQ(NREQ), .POUR_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_fluid(req_fluid),
    .req_volume(req_volume), .req_visits(req_visits),
    .refill_valid(refill_valid), .refill_fluid(refill_fluid), .refill_qty(refill_qty),
    .gnt(gnt), .valve_open(valve_open), .busy(busy), .done(done), .done_id(done_id),
    .status(status), .original_price(original_price), .discount_percent(discount_percent),
    .final_price(final_price), .remaining_qty(remaining_qty), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; req_fluid = '0; req_volume = '0; req_visits = '0;
    refill_valid = 1'b0; refill_fluid = '0; refill_qty = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [1:0] fluid, input int vol, input int visits);
    req_fluid[2*id +: 2]  = fluid;
    req_volume[8*id +: 8] = 8'(vol);
    req_visits[8*id +: 8] = 8'(visits);
    req[id] = 1'b1;
  endtask

  // exp_rem < 0 skips the remaining_qty check; refill_at > 0 pulses a refill
  // of the same fluid during that cycle after the sampling edge.
  task automatic run_req(input int id, input logic [1:0] fluid, input int vol, input int visits,
                         input int exp_status, input int exp_orig, input int exp_disc,
                         input int exp_final, input int exp_rem,
                         input int refill_at, input logic [15:0] rq);
    int   m;
    int   valve_cycles;
    int   exp_m;
    logic seen;
    logic valve_ok;
    logic [2:0] exp_valve;
    exp_valve = 3'b001 << fluid;
    exp_m = (exp_status == 0) ? 1 + vol * PC : 1;
    @(posedge clk); #1;
    set_req(id, fluid, vol, visits);
    @(posedge clk); #1;
    req[id] = 1'b0;
    check("gnt_first", 32'(gnt), 32'(1 << id));
    check("busy", 32'(busy), 1);
    m = 0; seen = 1'b0; valve_cycles = 0; valve_ok = 1'b1;
    while (!seen && m < 1200) begin
      if (valve_open != 3'b000) begin
        valve_cycles++;
        if (valve_open !== exp_valve) valve_ok = 1'b0;
      end
      if (refill_at != 0 && m == refill_at) begin
        refill_valid = 1'b1; refill_fluid = fluid; refill_qty = rq;
      end else begin
        refill_valid = 1'b0;
      end
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        m++;
      end
    end
    refill_valid = 1'b0;
    check("done_seen", 32'(seen), 1);
    check("latency", m, exp_m);
    check("valve_cycles", valve_cycles, (exp_status == 0) ? vol * PC : 0);
    check("valve_value", 32'(valve_ok), 1);
    check("gnt_in_done", 32'(gnt), 32'(1 << id));
    check("done_id", 32'(done_id), id);
    check("status", 32'(status), exp_status);
    check("original_price", 32'(original_price), exp_orig);
    check("discount", 32'(discount_percent), exp_disc);
    check("final_price", 32'(final_price), exp_final);
    if (exp_rem >= 0) check("remaining", 32'(remaining_qty), exp_rem);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 0);
    check("gnt_clear", 32'(gnt), 0);
    check("busy_clear", 32'(busy), 0);
  endtask

  initial begin
    int ndone;
    do_reset();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valve", 32'(valve_open), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_status", 32'(status), 0);
    check("rst_price", 32'(original_price), 0);
    check("rst_final", 32'(final_price), 0);
    check("rst_rem", 32'(remaining_qty), 0);

    // Accepted pours with each discount tier.
    run_req(0, 2'd0, 3, 1, 0, 40, 0, 40, 97, 0, 16'd0);
    run_req(2, 2'd1, 3, 3, 0, 110, 10, 99, 77, 0, 16'd0);
    run_req(3, 2'd2, 5, 7, 0, 120, 20, 96, 55, 0, 16'd0);

    // Rejects from reset stock.
    do_reset();
    run_req(1, 2'd2, 61, 5, 1, 0, 20, 0, 60, 0, 16'd0);
    run_req(1, 2'd3, 5, 0, 2, 0, 0, 0, -1, 0, 16'd0);
    run_req(1, 2'd0, 0, 3, 3, 0, 10, 0, 100, 0, 16'd0);

    // All requesters held: grants rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'd0, 1, 0);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    exp_q.push_back(8'd3); exp_q.push_back(8'd0);
    ndone = 0;
    for (int c = 0; c < 200 && ndone < 5; c++) begin
      @(posedge clk); #1;
      check("gnt_onehot", 32'($onehot0(gnt)), 1);
      if (done === 1'b1 && exp_q.size() > 0) begin
        check("rr_order", 32'(done_id), 32'(exp_q.pop_front()));
        ndone++;
        if (ndone == 5) req = '0;
      end
    end
    check("rr_count", ndone, 5);
    check("rr_queue_empty", exp_q.size(), 0);

    // Refill coinciding with the first debit, then saturation.
    do_reset();
    run_req(0, 2'd0, 2, 0, 0, 30, 0, 30, 103, PC, 16'd5);
    @(posedge clk); #1;
    refill_valid = 1'b1; refill_fluid = 2'd0; refill_qty = 16'hFFFF;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    run_req(1, 2'd0, 1, 0, 0, 20, 0, 20, 65534, 0, 16'd0);

    // Asynchronous reset in the middle of a chemical pour.
    @(posedge clk); #1;
    set_req(2, 2'd2, 5, 0);
    @(posedge clk); #1;
    req[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("mid_valve", 32'(valve_open), 32'b100);
    #2 reset = 1'b1;
    #1;
    check("arst_valve", 32'(valve_open), 0);
    check("arst_gnt", 32'(gnt), 0);
    check("arst_busy", 32'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    run_req(2, 2'd2, 1, 0, 0, 40, 0, 40, 59, 0, 16'd0);
    run_req(0, 2'd0, 1, 0, 0, 20, 0, 20, 99, 0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
